// File: rtl/rv_mem_port_arbiter.sv
// rtl/rv_mem_port_arbiter.sv - single-port memory bus arbiter between instruction fetch and data access
//
// Purpose:
//   Shares one memory bus between the fetch port (if_*) and the data port
//   (dm_*). The data port has fixed priority, and only one bus transaction is
//   in flight at a time. stall_if / stall_mem go to the pipeline hazard logic.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   if_req/if_addr  fetch request, held until if_ready
//   if_rdata        fetch data, valid with the 1-cycle if_ready pulse
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata
//                   data request, held until dm_ready
//   dm_rdata        load data, valid with the 1-cycle dm_ready pulse
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata
//                   registered bus request towards the slave
//   bus_rdata       slave read data, sampled with bus_ack
//   bus_ack         1-cycle slave completion
//   bus_err         1-cycle pulse with ready when a transfer timed out
//   stall_if        if_req & ~if_ready
//   stall_mem       dm_req & ~dm_ready
//
// Configuration:
//   ARB_STARVE_GUARD_EN  when defined, after STARVE_LIMIT consecutive data
//                        grants made while a fetch was waiting, the next
//                        arbitration with if_req=1 goes to the fetch port.

module rv_mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [DW-1:0]     if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DW/8-1:0]   dm_be,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    output logic [DW-1:0]     dm_rdata,
    output logic              dm_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DW/8-1:0]   bus_be,
    output logic [AW-1:0]     bus_addr,
    output logic [DW-1:0]     bus_wdata,
    input  logic [DW-1:0]     bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [BW-1:0]   bus_be_q, bus_be_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            if_ready_q, if_ready_d;
    logic            dm_ready_q, dm_ready_d;
    logic            bus_err_q, bus_err_d;
    logic [CW-1:0]   wait_q, wait_d;

    // Set when the fetch port must win the next arbitration despite dm_req.
    logic            if_forced;
    logic            grant_dm;
    logic            grant_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]   starve_q, starve_d;

    assign if_forced = if_req && (starve_q == SW'(STARVE_LIMIT));

    // Counts data grants taken while a fetch was waiting; any IF grant or a
    // data grant with no fetch pending breaks the run.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (grant_dm) begin
                if (!if_req) begin
                    starve_d = '0;
                end else if (starve_q != SW'(STARVE_LIMIT)) begin
                    starve_d = starve_q + SW'(1);
                end
            end else if (grant_if) begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    localparam int starve_limit_unused = STARVE_LIMIT;

    assign if_forced = 1'b0;
`endif

    assign grant_dm = dm_req && !if_forced;
    assign grant_if = if_req && !grant_dm;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        bus_err_d   = 1'b0;
        wait_d      = wait_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_dm) begin
                    state_d     = ST_DM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we;
                    bus_be_d    = dm_be;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                    wait_d      = '0;
                end else if (grant_if) begin
                    state_d     = ST_IF_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    wait_d      = '0;
                end
            end

            ST_IF_BUSY, ST_DM_BUSY: begin
                // An ack in the same cycle the counter hits TIMEOUT still
                // completes normally, so ack is tested first.
                if (bus_ack) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    if (state_q == ST_IF_BUSY) begin
                        if_rdata_d = bus_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_rdata_d = bus_rdata;
                        dm_ready_d = 1'b1;
                    end
                end else if (wait_q == CW'(TIMEOUT)) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == ST_IF_BUSY) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_rdata_d = '0;
                        dm_ready_d = 1'b1;
                    end
                end else if (wait_q != {CW{1'b1}}) begin
                    wait_d = wait_q + CW'(1);
                end
            end

            ST_RESP: begin
                // Ready pulses this cycle; the requester drops or changes its
                // request before arbitration resumes in IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            bus_err_q   <= bus_err_d;
            wait_q      <= wait_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign bus_err   = bus_err_q;

    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = dm_req & ~dm_ready_q;

endmodule
